// File: rtl/mem_arbiter_if.sv
// Bundle of the I-fetch, load/store and mem-side signals around mem_arbiter.
// The arbiter uses the slave modport; the requesters plus the memory use master.
interface mem_arbiter_if #(parameter int BUS_WIDTH = 32);
  logic                 i_req;
  logic [BUS_WIDTH-1:0] i_addr;
  logic                 i_gnt;
  logic                 i_rvalid;
  logic [BUS_WIDTH-1:0] i_rdata;
  logic                 i_err;

  logic                 d_req;
  logic                 d_we;
  logic [BUS_WIDTH-1:0] d_addr;
  logic [BUS_WIDTH-1:0] d_wdata;
  logic [1:0]           d_size;
  logic                 d_sx;
  logic                 d_gnt;
  logic                 d_rvalid;
  logic [BUS_WIDTH-1:0] d_rdata;
  logic                 d_err;

  logic [BUS_WIDTH-1:0] m_addr;
  logic [BUS_WIDTH-1:0] m_wdata;
  logic                 m_wr_en;
  logic [1:0]           m_size;
  logic                 m_sz_ex;
  logic [BUS_WIDTH-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size, d_sx, m_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output m_addr, m_wdata, m_wr_en, m_size, m_sz_ex
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_size, d_sx, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  m_addr, m_wdata, m_wr_en, m_size, m_sz_ex
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-addressable mem between instruction fetch (I) and load/store (D).
// Default: D-priority with MAX_BURST starvation guard; define ARB_ROUND_ROBIN_EN for alternation.
module mem_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter int MEM_BYTES = 256,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [BUS_WIDTH:0] LIMIT = (BUS_WIDTH+1)'(MEM_BYTES);

  // Range check is done one bit wider so addresses near the top cannot wrap.
  function automatic logic acc_err(input logic [BUS_WIDTH-1:0] addr, input logic [1:0] size);
    logic             mis;
    logic [BUS_WIDTH:0] nb;
    mis = 1'b0;
    nb  = (BUS_WIDTH+1)'(4);
    case (size)
      2'b00:   nb = (BUS_WIDTH+1)'(1);
      2'b01:   begin nb = (BUS_WIDTH+1)'(2); mis = addr[0]; end
      2'b10:   mis = |addr[1:0];
      default: mis = 1'b1;
    endcase
    acc_err = mis | (({1'b0, addr} + nb) > LIMIT);
  endfunction

  logic i_err_c, d_err_c;
  logic i_win, d_win;

  assign i_err_c = acc_err(bus.i_addr, 2'b10);
  assign d_err_c = acc_err(bus.d_addr, bus.d_size);

`ifdef ARB_ROUND_ROBIN_EN
  // rr_i_q=1 means I is preferred on the next contended cycle.
  logic rr_i_q, rr_i_d;

  always_comb begin
    i_win  = bus.i_req;
    d_win  = bus.d_req;
    if (bus.i_req && bus.d_req) begin
      i_win = rr_i_q;
      d_win = !rr_i_q;
    end
    rr_i_d = rr_i_q;
    if (i_win)      rr_i_d = 1'b0;
    else if (d_win) rr_i_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_i_q <= 1'b1;
    else      rr_i_q <= rr_i_d;
  end
`else
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] burst_q, burst_d;

  // burst counts D grants taken while I was waiting.
  always_comb begin
    i_win = bus.i_req;
    d_win = bus.d_req;
    if (bus.i_req && bus.d_req) begin
      i_win = (burst_q == CW'(MAX_BURST));
      d_win = !i_win;
    end
    burst_d = burst_q;
    if (i_win || (!bus.i_req && bus.d_req)) burst_d = '0;
    else if (d_win)                          burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) burst_q <= '0;
    else      burst_q <= burst_d;
  end
`endif

  assign bus.i_gnt = rst & i_win;
  assign bus.d_gnt = rst & d_win;

  always_comb begin
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wr_en = 1'b0;
    bus.m_size  = 2'b10;
    bus.m_sz_ex = 1'b0;
    if (bus.i_gnt) begin
      bus.m_addr = bus.i_addr;
    end else if (bus.d_gnt) begin
      bus.m_addr  = bus.d_addr;
      bus.m_wdata = bus.d_wdata;
      bus.m_wr_en = bus.d_we & !d_err_c;
      bus.m_size  = bus.d_size;
      bus.m_sz_ex = bus.d_sx;
    end
  end

  logic                 i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
  logic                 d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
  logic [BUS_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  always_comb begin
    i_rvalid_d = bus.i_gnt;
    i_err_d    = bus.i_gnt & i_err_c;
    i_rdata_d  = (bus.i_gnt && !i_err_c) ? bus.m_rdata : '0;
    d_rvalid_d = bus.d_gnt;
    d_err_d    = bus.d_gnt & d_err_c;
    d_rdata_d  = (bus.d_gnt && !d_err_c && !bus.d_we) ? bus.m_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      i_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      i_rvalid_q <= i_rvalid_d;
      i_err_q    <= i_err_d;
      i_rdata_q  <= i_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_err_q    <= d_err_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.i_rvalid = i_rvalid_q;
  assign bus.i_err    = i_err_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_err    = d_err_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule
